// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// regfile_wb_arbiter : register-file write-back arbiter (ALU vs buffered loads)
// with a pending-load scoreboard for decode hazards.            Rev 1.0
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_wb_addr,
  input  logic [DATA_WIDTH-1:0]         alu_wb_data,
  output logic                          alu_wb_ready,
  input  logic                          ld_issue_valid,
  input  logic [ADDR_WIDTH-1:0]         ld_issue_addr,
  input  logic                          ld_rsp_valid,
  input  logic [ADDR_WIDTH-1:0]         ld_rsp_addr,
  input  logic [DATA_WIDTH-1:0]         ld_rsp_data,
  output logic                          ld_rsp_ready,
  output logic                          rf_wr_en,
  output logic [ADDR_WIDTH-1:0]         rf_wr_addr,
  output logic [DATA_WIDTH-1:0]         rf_wr_data,
  input  logic [ADDR_WIDTH-1:0]         rs1_addr,
  input  logic [ADDR_WIDTH-1:0]         rs2_addr,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic [NREG-1:0]       sb_q, sb_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;

  logic                  fifo_nonempty, fifo_full, fifo_grant, alu_grant, push;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  // Arbitration looks only at registered FIFO state, so a response cannot bypass.
  assign fifo_nonempty = (count_q != '0);
  assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_addr     = fifo_addr_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];
  assign fifo_grant    = fifo_nonempty &&
                         (!alu_wb_valid || fifo_full || (starve_q == STV_W'(STARVE_LIMIT)));
  assign alu_grant     = alu_wb_valid && !fifo_grant;
  assign push          = ld_rsp_valid && ld_rsp_ready;

  assign alu_wb_ready  = alu_grant;
  assign ld_rsp_ready  = !fifo_full;
  assign fifo_count    = count_q;
  assign rs1_busy      = sb_q[rs1_addr];
  assign rs2_busy      = sb_q[rs2_addr];
  assign rf_wr_en      = rf_wr_en_q;
  assign rf_wr_addr    = rf_wr_addr_q;
  assign rf_wr_data    = rf_wr_data_q;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = ld_rsp_addr;
      fifo_data_d[wr_ptr_q] = ld_rsp_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_grant) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(fifo_grant);
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_grant || !fifo_nonempty) begin
      starve_d = '0;
    end else if (alu_grant && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // Clear before set so a same-cycle issue to the retiring register stays pending.
  always_comb begin
    sb_d = sb_q;
    if (fifo_grant) begin
      sb_d[head_addr] = 1'b0;
    end
    if (ld_issue_valid && (ld_issue_addr != '0)) begin
      sb_d[ld_issue_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    if (fifo_grant) begin
      rf_wr_en_d   = (head_addr != '0);
      rf_wr_addr_d = head_addr;
      rf_wr_data_d = head_data;
    end else if (alu_grant) begin
      rf_wr_en_d   = (alu_wb_addr != '0);
      rf_wr_addr_d = alu_wb_addr;
      rf_wr_data_d = alu_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      sb_q         <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      fifo_addr_q  <= fifo_addr_d;
      fifo_data_q  <= fifo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      sb_q         <= sb_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter : directed + randomized bench against a queue-based
// reference model of the write-back arbiter.                    Rev 1.0
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_wb_valid, alu_wb_ready;
  logic [AW-1:0] alu_wb_addr;
  logic [DW-1:0] alu_wb_data;
  logic          ld_issue_valid;
  logic [AW-1:0] ld_issue_addr;
  logic          ld_rsp_valid, ld_rsp_ready;
  logic [AW-1:0] ld_rsp_addr;
  logic [DW-1:0] ld_rsp_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic          rs1_busy, rs2_busy;
  logic [1:0]    fifo_count;

  regfile_wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_addr(ld_rsp_addr), .ld_rsp_data(ld_rsp_data),
    .ld_rsp_ready(ld_rsp_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model state
  ent_t          m_q[$];
  bit [31:0]     m_sb;
  int            m_starve;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            last_acc;
  bit            last_alu_ready;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sb     = '0;
    m_starve = 0;
    m_en     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic idle();
    alu_wb_valid   = 1'b0;
    ld_issue_valid = 1'b0;
    ld_rsp_valid   = 1'b0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registers.
  task automatic cycle();
    bit   fifo_win, alu_win;
    int   n;
    ent_t h;
    @(negedge clk);
    n        = m_q.size();
    fifo_win = (n != 0) && (!alu_wb_valid || n == DEPTH || m_starve == LIMIT);
    alu_win  = alu_wb_valid && !fifo_win;
    last_alu_ready = alu_wb_ready;
    check("alu_wb_ready", alu_wb_ready, alu_win);
    check("ld_rsp_ready", ld_rsp_ready, n < DEPTH);
    check("fifo_count", fifo_count, n);
    check("rs1_busy", rs1_busy, m_sb[rs1_addr]);
    check("rs2_busy", rs2_busy, m_sb[rs2_addr]);
    last_acc = ld_rsp_valid && (n < DEPTH);
    m_en = 1'b0;
    if (fifo_win) begin
      h      = m_q.pop_front();
      m_en   = (h.a != 0);
      m_addr = h.a;
      m_data = h.d;
      m_sb[h.a] = 1'b0;
      m_starve  = 0;
    end else if (n == 0) begin
      m_starve = 0;
    end else if (alu_win && m_starve < LIMIT) begin
      m_starve++;
    end
    if (alu_win) begin
      m_en   = (alu_wb_addr != 0);
      m_addr = alu_wb_addr;
      m_data = alu_wb_data;
    end
    if (ld_issue_valid && ld_issue_addr != 0) m_sb[ld_issue_addr] = 1'b1;
    if (last_acc) m_q.push_back({ld_rsp_addr, ld_rsp_data});
    @(posedge clk);
    #1;
    check("rf_wr_en", rf_wr_en, m_en);
    check("rf_wr_addr", rf_wr_addr, m_addr);
    check("rf_wr_data", rf_wr_data, m_data);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    alu_wb_addr = '0; alu_wb_data = '0;
    ld_issue_addr = '0; ld_rsp_addr = '0; ld_rsp_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    model_reset();
    #12;
    check("rst_wr_en", rf_wr_en, 1'b0);
    check("rst_wr_addr", rf_wr_addr, 0);
    check("rst_wr_data", rf_wr_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ld_ready", ld_rsp_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU only
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEADBEEF;
    cycle();
    idle();
    check("alu_grant", last_alu_ready, 1'b1);
    check("alu_wb_data", rf_wr_data, 32'hDEADBEEF);

    // Load path: issue 7, return 7, write two cycles after response
    ld_issue_valid = 1'b1; ld_issue_addr = 5'd7; rs1_addr = 5'd7;
    cycle();
    idle();
    check("busy7_set", rs1_busy, 1'b1);
    ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd7; ld_rsp_data = 32'h12;
    cycle();
    idle();
    check("ld_no_bypass", rf_wr_en, 1'b0);
    cycle();
    check("ld_wb_en", rf_wr_en, 1'b1);
    check("ld_wb_addr", rf_wr_addr, 7);
    check("busy7_clr", rs1_busy, 1'b0);

    // Full FIFO priority, then starvation release of the second entry
    ld_issue_valid = 1'b1; ld_issue_addr = 5'd3; cycle();
    ld_issue_addr = 5'd4; cycle();
    ld_issue_valid = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd11; alu_wb_data = 32'hA5A5_0001;
    ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd3; ld_rsp_data = 32'h333; cycle();
    ld_rsp_addr = 5'd4; ld_rsp_data = 32'h444; cycle();
    ld_rsp_valid = 1'b0;
    check("full_ready", ld_rsp_ready, 1'b0);
    cycle();
    check("full_fifo_wins", last_alu_ready, 1'b0);
    check("full_wb_addr", rf_wr_addr, 3);
    for (int k = 0; k < 6; k++) cycle();
    idle();
    cycle(); cycle();

    // Starvation: one buffered load, ALU continuously valid
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd12; alu_wb_data = 32'h5555;
    ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd10; ld_rsp_data = 32'hAAAA;
    cycle();
    ld_rsp_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("starve_alu_ready", last_alu_ready, k < 4);
    end
    check("starve_wb_addr", rf_wr_addr, 10);
    idle();
    cycle();

    // ALU write to r0 is consumed without a write
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd0; alu_wb_data = 32'hFFFF;
    cycle();
    idle();
    check("r0_ready", last_alu_ready, 1'b1);
    check("r0_no_write", rf_wr_en, 1'b0);

    // Same-cycle issue and retirement of r9: set wins
    ld_issue_valid = 1'b1; ld_issue_addr = 5'd9; rs1_addr = 5'd9; cycle();
    ld_issue_valid = 1'b0;
    ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd9; ld_rsp_data = 32'h99; cycle();
    ld_rsp_valid = 1'b0; ld_issue_valid = 1'b1; cycle();
    idle();
    check("busy9_set_wins", rs1_busy, 1'b1);
    check("r9_written", rf_wr_addr, 9);

    // Async reset mid-operation with two buffered loads
    ld_issue_valid = 1'b1; ld_issue_addr = 5'd3; cycle();
    ld_issue_addr = 5'd4; cycle();
    ld_issue_valid = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd13; alu_wb_data = 32'h1313;
    ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd3; ld_rsp_data = 32'h3; cycle();
    ld_rsp_addr = 5'd4; ld_rsp_data = 32'h4; cycle();
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    check("pre_rst_count", fifo_count, 2);
    check("pre_rst_busy", rs2_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", fifo_count, 0);
    check("arst_wr_en", rf_wr_en, 1'b0);
    check("arst_rs1", rs1_busy, 1'b0);
    check("arst_rs2", rs2_busy, 1'b0);
    check("arst_ready", ld_rsp_ready, 1'b1);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic; a refused response is held until accepted
    last_acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      alu_wb_valid   = ($urandom_range(0, 99) < 60);
      alu_wb_addr    = AW'($urandom_range(0, 31));
      alu_wb_data    = $urandom;
      ld_issue_valid = ($urandom_range(0, 99) < 30);
      ld_issue_addr  = AW'($urandom_range(0, 31));
      if (!ld_rsp_valid || last_acc) begin
        ld_rsp_valid = ($urandom_range(0, 99) < 45);
        ld_rsp_addr  = AW'($urandom_range(0, 31));
        ld_rsp_data  = $urandom;
      end
      rs1_addr = AW'($urandom_range(0, 31));
      rs2_addr = AW'($urandom_range(0, 31));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
